// File: rtl/cdc_toggle_handshake_rx.sv
// Destination side of a toggle-based req/ack clock-domain crossing.
// A request toggle from a foreign domain is synchronized into sys_clk, the
// sender-held data bus is captured one cycle after the synchronized request
// settles, and the word is offered on a valid/ready port. Completing the
// handshake flips the acknowledge level back to the sender.
module cdc_toggle_handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_ack,
    output logic              o_busy,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state;

    // Only the first stage samples the asynchronous request; the attribute
    // keeps the chain co-placed so metastability has a full cycle to resolve.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_chain;

    logic req_sync;
    logic req_d;
    logic req_edge;
    logic pending;

    assign req_sync = sync_chain[SYNC_STAGES-1];
    assign req_edge = req_sync ^ req_d;
    assign pending  = (req_sync != o_ack);
    assign o_busy   = (state != IDLE);

    // Request synchronizer plus a delayed copy used to spot request toggles.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync_chain <= '0;
            req_d      <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], i_req};
            req_d      <= req_sync;
        end
    end

    // Transfer FSM: wait for an unacknowledged request, capture, then hold the
    // word until the consumer takes it and flip the acknowledge level.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_ack      <= 1'b0;
            o_err      <= 1'b0;
            o_xfer_cnt <= '0;
        end else begin
            if (req_edge && (state != IDLE)) begin
                o_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pending) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    o_data  <= i_data;
                    o_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid    <= 1'b0;
                        o_ack      <= ~o_ack;
                        o_xfer_cnt <= o_xfer_cnt + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_toggle_handshake_rx.sv
// Scoreboard bench for cdc_toggle_handshake_rx. The stimulus process pushes
// each word it expects to see delivered; a monitor pops and compares on every
// valid/ready handshake. A small counter width keeps the wrap reachable.
module tb_cdc_toggle_handshake_rx;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;

    logic              sys_clk = 1'b0;
    logic              rst_n   = 1'b0;
    logic              i_req   = 1'b0;
    logic [DATA_W-1:0] i_data  = '0;
    logic              i_ready = 1'b0;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_ack;
    logic              o_busy;
    logic              o_err;
    logic [CNT_W-1:0]  o_xfer_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic              req_level = 1'b0;
    logic              exp_ack   = 1'b0;
    logic [CNT_W-1:0]  exp_cnt   = '0;
    int                ready_mode = 1;
    logic              ack_s1 = 1'b0;
    logic              ack_s2 = 1'b0;

    cdc_toggle_handshake_rx #(
        .DATA_W(DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W(CNT_W)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .i_req(i_req),
        .i_data(i_data),
        .i_ready(i_ready),
        .o_valid(o_valid),
        .o_data(o_data),
        .o_ack(o_ack),
        .o_busy(o_busy),
        .o_err(o_err),
        .o_xfer_cnt(o_xfer_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Sender-domain model of the acknowledge 2-FF synchronizer.
    always @(posedge sys_clk) begin
        ack_s1 <= o_ack;
        ack_s2 <= ack_s1;
    end

    // Consumer ready driver: 0 = low, 1 = high, 2 = random; updated mid-cycle.
    initial begin
        forever begin
            @(posedge sys_clk);
            #2;
            if (ready_mode == 2) i_ready = 1'($urandom_range(0, 1));
            else                 i_ready = (ready_mode == 1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake must deliver the oldest expected word.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (rst_n && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_word: got 0x%0h expected none at %0t", o_data, $time);
                end else begin
                    checkOutput("scoreboard_data", 32'(o_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] d);
        i_data    = d;
        req_level = ~req_level;
        i_req     = req_level;
    endtask

    task automatic note_xfer();
        exp_ack = ~exp_ack;
        exp_cnt = exp_cnt + CNT_W'(1);
    endtask

    task automatic wait_sync_ack();
        int n;
        n = 0;
        while (ack_s2 !== req_level && n < 100) begin
            tick();
            n++;
        end
        if (ack_s2 !== req_level) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL ack_timeout: got %0b expected %0b", ack_s2, req_level);
        end
        tick(2);
    endtask

    initial begin
        // Reset held with a raised request: everything reads zero.
        i_req     = 1'b1;
        req_level = 1'b1;
        i_data    = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("reset_outputs", {o_valid, o_ack, o_busy, o_err, 4'(o_xfer_cnt), o_data},
                        32'h0);
        end
        exp_q.push_back(8'h3C);
        rst_n = 1'b1;
        note_xfer();
        wait_sync_ack();
        checkOutput("reset_one_xfer_cnt", 32'(o_xfer_cnt), 32'(exp_cnt));
        checkOutput("reset_one_xfer_ack", 32'(o_ack), 32'(exp_ack));

        // Single transfer with ready high: exact edge timing.
        ready_mode = 1;
        tick();
        exp_q.push_back(8'hA5);
        applyStimulus(8'hA5);
        tick(3);
        checkOutput("single_valid_e2", 32'(o_valid), 32'h0);
        checkOutput("single_busy_e2", 32'(o_busy), 32'h1);
        tick();
        checkOutput("single_valid_e3", 32'(o_valid), 32'h1);
        checkOutput("single_data_e3", 32'(o_data), 32'hA5);
        checkOutput("single_ack_e3", 32'(o_ack), 32'(exp_ack));
        note_xfer();
        tick();
        checkOutput("single_valid_e4", 32'(o_valid), 32'h0);
        checkOutput("single_ack_e4", 32'(o_ack), 32'(exp_ack));
        checkOutput("single_cnt_e4", 32'(o_xfer_cnt), 32'(exp_cnt));
        checkOutput("single_err", 32'(o_err), 32'h0);
        wait_sync_ack();

        // Backpressure: ten stalled cycles, then release.
        ready_mode = 0;
        tick();
        exp_q.push_back(8'hA5);
        applyStimulus(8'hA5);
        tick(4);
        for (int k = 0; k < 10; k++) begin
            checkOutput("bp_hold", {o_valid, o_ack, 8'h0, o_data}, {1'b1, exp_ack, 8'h0, 8'hA5});
            tick();
        end
        ready_mode = 1;
        note_xfer();
        tick();
        checkOutput("bp_release_valid", 32'(o_valid), 32'h0);
        checkOutput("bp_release_ack", 32'(o_ack), 32'(exp_ack));
        wait_sync_ack();

        // Back-to-back words with a random consumer.
        ready_mode = 2;
        for (int w = 1; w <= 4; w++) begin
            exp_q.push_back(8'(w));
            applyStimulus(8'(w));
            note_xfer();
            wait_sync_ack();
        end
        ready_mode = 1;
        tick(3);
        checkOutput("b2b_ack", 32'(o_ack), 32'(exp_ack));
        checkOutput("b2b_cnt", 32'(o_xfer_cnt), 32'(exp_cnt));
        checkOutput("b2b_err", 32'(o_err), 32'h0);
        checkOutput("b2b_queue_empty", 32'(exp_q.size()), 32'h0);

        // Protocol violation: second toggle while the word is still held.
        ready_mode = 0;
        tick();
        exp_q.push_back(8'h5A);
        applyStimulus(8'h5A);
        tick(4);
        checkOutput("viol_valid", 32'(o_valid), 32'h1);
        applyStimulus(8'hFF);
        tick(2);
        checkOutput("viol_err_early", 32'(o_err), 32'h0);
        tick();
        checkOutput("viol_err_set", 32'(o_err), 32'h1);
        checkOutput("viol_data_held", 32'(o_data), 32'h5A);
        tick(5);
        checkOutput("viol_err_sticky", 32'(o_err), 32'h1);
        // The held word completes, then the re-toggled level yields one spurious transfer.
        exp_q.push_back(8'hFF);
        note_xfer();
        note_xfer();
        ready_mode = 1;
        tick(20);
        checkOutput("viol_cnt", 32'(o_xfer_cnt), 32'(exp_cnt));
        checkOutput("viol_ack", 32'(o_ack), 32'(exp_ack));
        checkOutput("viol_err_after", 32'(o_err), 32'h1);

        // Run the counter up to its top value, then wrap it.
        for (int g = 0; g < 40 && exp_cnt != {CNT_W{1'b1}}; g++) begin
            exp_q.push_back(8'(8'h80 + g));
            applyStimulus(8'(8'h80 + g));
            note_xfer();
            tick(12);
        end
        checkOutput("cnt_top", 32'(o_xfer_cnt), 32'hF);
        exp_q.push_back(8'hC3);
        applyStimulus(8'hC3);
        note_xfer();
        tick(12);
        checkOutput("cnt_wrap", 32'(o_xfer_cnt), 32'h0);

        // Reset while holding a word: the transfer is dropped.
        ready_mode = 0;
        tick();
        applyStimulus(8'h77);
        tick(4);
        checkOutput("midrst_in_out", 32'(o_valid), 32'h1);
        rst_n     = 1'b0;
        req_level = 1'b0;
        i_req     = 1'b0;
        tick();
        checkOutput("midrst_outputs", {o_valid, o_ack, o_busy, o_err, 4'(o_xfer_cnt)}, 32'h0);
        rst_n = 1'b1;
        tick(8);
        checkOutput("midrst_idle", {o_valid, o_ack, o_busy}, 32'h0);
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cdc_toggle_handshake_rx.md
Name: cdc_toggle_handshake_rx

Overview:
- Single-clock destination side of the toggle-based req/ack CDC handshake.
- Synchronizes an asynchronous request toggle from a foreign clock domain and captures a multi-bit data bus that the sender holds stable until acknowledged.
- Presents the captured word on a valid/ready interface and returns an acknowledge toggle level. The sender's domain synchronizes that level back with its own 2-FF chain.
- Sits at every multi-bit crossing into the sys_clk domain, beside the existing 1-bit synchronizers.

Parameters:
DATA_W, 8, width of transferred data word
SYNC_STAGES, 2, flops in request synchronizer chain (legal >= 2)
CNT_W, 16, width of completed-transfer counter

Ports:
sys_clk  input  1  destination clock, all logic posedge
rst_n  input  1  synchronous active-low reset
i_req  input  1  request toggle from sender domain (asynchronous to sys_clk)
i_data  input  DATA_W  sender data, asynchronous, must be stable from req toggle until ack toggle seen
i_ready  input  1  downstream consumer ready
o_valid  output  1  o_data holds a captured word
o_data  output  DATA_W  captured word
o_ack  output  1  acknowledge toggle level, returned to sender domain
o_busy  output  1  high whenever state != IDLE
o_err  output  1  sticky protocol-violation flag
o_xfer_cnt  output  CNT_W  count of completed transfers

Behaviour:
- Reset (rst_n low at posedge): sync chain = 0, req_d = 0, state = IDLE, o_valid = 0, o_data = 0, o_ack = 0, o_err = 0, o_xfer_cnt = 0. Reset has priority over all other logic.
- Sync chain:
  - i_req is shifted through SYNC_STAGES flops; req_sync = last stage.
  - Only the first stage touches i_req. Mark the chain ASYNC for co-placement.
  - req_d registers req_sync; req_edge = req_sync ^ req_d.
- pending = (req_sync != o_ack), combinational.
- FSM states:
  - IDLE: if pending -> CAPT.
  - CAPT: o_data <= i_data; o_valid <= 1; -> OUT. The CAPT cycle is the settle margin: i_data is sampled only once req_sync has passed the full chain.
  - OUT: o_valid and o_data held. If i_ready (handshake): o_valid <= 0, o_ack <= ~o_ack, o_xfer_cnt <= o_xfer_cnt + 1, -> IDLE. Otherwise stay in OUT.
- After the ack toggle, pending is 0 until the sender toggles i_req again. IDLE therefore lasts at least 1 cycle between transfers.
- Latency: i_req toggles before edge 0. req_sync updates at edge SYNC_STAGES-1; state is CAPT at edge SYNC_STAGES; o_valid = 1 after edge SYNC_STAGES+1. With i_ready already high, o_ack toggles and o_valid drops at edge SYNC_STAGES+2.
- Backpressure: any number of i_ready = 0 cycles. o_data must not change and o_ack must not toggle.
- i_ready while o_valid = 0 is ignored.
- Protocol error: req_edge = 1 while state != IDLE sets o_err = 1, sticky until reset.
  - The current transfer still completes normally.
  - After its ack, the pending rule applies unchanged (a spurious extra transfer may follow). No other recovery.
- o_xfer_cnt wraps from 2^CNT_W-1 to 0 silently.
- Reset mid-transfer: the transfer is dropped and o_ack returns to 0. Sender domain must be reset in the same event.
  - If i_req is 1 after reset release, one transfer is taken (req_sync 1 != o_ack 0). This is required behaviour.
- o_busy is combinational from state only.
- All outputs are registered except o_busy.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with i_req = 1, then release. All outputs are 0 during reset. Afterwards exactly one transfer occurs, o_xfer_cnt = 1.
- Single transfer (SYNC_STAGES = 2): i_data = 0xA5, i_req 0->1 before edge 0, i_ready = 1 -> o_valid = 1, o_data = 0xA5 after edge 3; o_ack = 1, o_valid = 0 after edge 4; o_xfer_cnt = 1, o_err = 0.
- Backpressure: as above but i_ready = 0 for 10 cycles after o_valid. o_valid stays 1, o_data stays 0xA5, o_ack stays 0 throughout. Raise i_ready -> o_ack = 1 and o_valid = 0 after the next edge.
- Back-to-back: bench sender toggles i_req for 0x01, 0x02, 0x03, 0x04, each after its 2-FF-synced ack toggle; random i_ready. Outputs arrive in order 0x01..0x04 with no loss or duplicate; final o_ack = 0, o_xfer_cnt = 4, o_err = 0.
- Protocol violation: while in OUT with i_ready = 0, toggle i_req again. o_err = 1 two edges later and remains 1; o_data unchanged until handshake; o_err cleared only by rst_n = 0.
- Reset mid-op plus counter wrap:
  - Preload via 65535 transfers (CNT_W = 16); the next transfer gives o_xfer_cnt = 0.
  - Assert rst_n = 0 in OUT -> after that edge o_valid = 0, o_ack = 0, o_busy = 0.
